// File: rtl/axis_stereo_gain_ramp.sv
// Stereo Q1.15 gain stage: per-sample gain ramping toward programmed targets,
// click-free mute, round-half-up, saturation with sticky clip flag, AXI-Stream backpressure.
module axis_stereo_gain_ramp #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16,
  parameter int RAMP_STEP  = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [GAIN_WIDTH-1:0] gain_l_target,
  input  logic [GAIN_WIDTH-1:0] gain_r_target,
  input  logic                  gain_update,
  input  logic                  mute,
  input  logic                  clear_sat,
  output logic                  ramp_active,
  output logic                  sat_sticky
);

  localparam int SW   = DATA_WIDTH / 2;
  localparam int PW   = SW + GAIN_WIDTH + 1;
  localparam int FRAC = GAIN_WIDTH - 1;
  localparam logic [GAIN_WIDTH-1:0] UNITY = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0] STEP  = GAIN_WIDTH'(RAMP_STEP);
  localparam logic [PW:0]           RND   = {{PW{1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RAMP = 1'b1} state_t;

  // Move cur at most STEP toward eff; snaps onto eff when within one step.
  function automatic logic [GAIN_WIDTH-1:0] f_ramp(input logic [GAIN_WIDTH-1:0] cur,
                                                   input logic [GAIN_WIDTH-1:0] eff);
    logic [GAIN_WIDTH-1:0] diff;
    if (eff >= cur) begin
      diff = eff - cur;
      if (diff <= STEP) f_ramp = eff;
      else              f_ramp = cur + STEP;
    end else begin
      diff = cur - eff;
      if (diff <= STEP) f_ramp = eff;
      else              f_ramp = cur - STEP;
    end
  endfunction

  // Returns {clip, sample}: round half up, arithmetic shift, clamp to signed SW bits.
  function automatic logic [SW:0] f_round_sat(input logic [PW-1:0] p);
    logic signed [PW:0] sum;
    logic signed [PW:0] sh;
    sum = {p[PW-1], p} + RND;
    sh  = sum >>> FRAC;
    if ((&sh[PW:SW-1]) || !(|sh[PW:SW-1])) f_round_sat = {1'b0, sh[SW-1:0]};
    else if (sh[PW])                       f_round_sat = {1'b1, 1'b1, {(SW-1){1'b0}}};
    else                                   f_round_sat = {1'b1, 1'b0, {(SW-1){1'b1}}};
  endfunction

  logic                  w_en, w_accept;
  logic [GAIN_WIDTH-1:0] r_tgt_l, r_tgt_r, r_cur_l, r_cur_r;
  logic [GAIN_WIDTH-1:0] w_eff_l, w_eff_r, w_next_l, w_next_r;
  logic [PW-1:0]         w_smp_l, w_smp_r, w_gain_l, w_gain_r, w_prod_l, w_prod_r;
  logic [PW-1:0]         r_s1_prod_l, r_s1_prod_r;
  logic                  r_s1_valid, r_s1_last;
  logic [SW:0]           w_rs_l, w_rs_r;
  state_t                r_state, w_state_nxt;

  assign w_en          = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = w_en;
  assign w_accept      = s_axis_tvalid && w_en;
  assign ramp_active   = (r_state == ST_RAMP);

  // Sign-extended samples times zero-extended gains; low PW bits are the exact product.
  assign w_smp_l  = {{(PW-SW){s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata[DATA_WIDTH-1:SW]};
  assign w_smp_r  = {{(PW-SW){s_axis_tdata[SW-1]}}, s_axis_tdata[SW-1:0]};
  assign w_gain_l = {{(PW-GAIN_WIDTH){1'b0}}, r_cur_l};
  assign w_gain_r = {{(PW-GAIN_WIDTH){1'b0}}, r_cur_r};
  assign w_prod_l = w_smp_l * w_gain_l;
  assign w_prod_r = w_smp_r * w_gain_r;
  assign w_rs_l   = f_round_sat(r_s1_prod_l);
  assign w_rs_r   = f_round_sat(r_s1_prod_r);
  assign w_next_l = f_ramp(r_cur_l, w_eff_l);
  assign w_next_r = f_ramp(r_cur_r, w_eff_r);

  // Effective target: mute forces zero without disturbing the latched target.
  always_comb begin
    w_eff_l = r_tgt_l;
    w_eff_r = r_tgt_r;
    if (mute) begin
      w_eff_l = {GAIN_WIDTH{1'b0}};
      w_eff_r = {GAIN_WIDTH{1'b0}};
    end else begin
      w_eff_l = r_tgt_l;
      w_eff_r = r_tgt_r;
    end
  end

  // Multiply and round/saturate stages, both advancing on the global enable.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s1_valid    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_prod_l   <= {PW{1'b0}};
      r_s1_prod_r   <= {PW{1'b0}};
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {DATA_WIDTH{1'b0}};
      m_axis_tlast  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid    <= s_axis_tvalid;
      m_axis_tvalid <= r_s1_valid;
      if (s_axis_tvalid) begin
        r_s1_last   <= s_axis_tlast;
        r_s1_prod_l <= w_prod_l;
        r_s1_prod_r <= w_prod_r;
      end
      if (r_s1_valid) begin
        m_axis_tdata <= {w_rs_l[SW-1:0], w_rs_r[SW-1:0]};
        m_axis_tlast <= r_s1_last;
      end
    end
  end

  // Sticky clip flag; a clip in the same cycle as clear_sat keeps it set.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sat_sticky <= 1'b0;
    end else if (w_en && r_s1_valid && (w_rs_l[SW] || w_rs_r[SW])) begin
      sat_sticky <= 1'b1;
    end else if (clear_sat) begin
      sat_sticky <= 1'b0;
    end
  end

  // Target latch and per-accepted-sample gain ramp (after that sample used the old gain).
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tgt_l <= UNITY;
      r_tgt_r <= UNITY;
      r_cur_l <= UNITY;
      r_cur_r <= UNITY;
    end else begin
      if (gain_update) begin
        r_tgt_l <= gain_l_target;
        r_tgt_r <= gain_r_target;
      end
      if (w_accept) begin
        r_cur_l <= w_next_l;
        r_cur_r <= w_next_r;
      end
    end
  end

  // Ramp state register.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Enter RAMP on any gain/target mismatch; leave only once an update lands both on target.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if ((r_cur_l != w_eff_l) || (r_cur_r != w_eff_r)) w_state_nxt = ST_RAMP;
        else                                               w_state_nxt = ST_IDLE;
      end
      ST_RAMP: begin
        if (w_accept && (w_next_l == w_eff_l) && (w_next_r == w_eff_r)) w_state_nxt = ST_IDLE;
        else                                                             w_state_nxt = ST_RAMP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_stereo_gain_ramp.sv
// Scoreboard bench for axis_stereo_gain_ramp: a behavioural gain/ramp model predicts
// every output sample at acceptance time; scenario tasks add inline control/status checks.
module tb_axis_stereo_gain_ramp;

  logic        aclk;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] gain_l_target;
  logic [15:0] gain_r_target;
  logic        gain_update;
  logic        mute;
  logic        clear_sat;
  logic        ramp_active;
  logic        sat_sticky;

  axis_stereo_gain_ramp dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .gain_l_target (gain_l_target),
    .gain_r_target (gain_r_target),
    .gain_update   (gain_update),
    .mute          (mute),
    .clear_sat     (clear_sat),
    .ramp_active   (ramp_active),
    .sat_sticky    (sat_sticky)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [32:0] sb_q[$];
  logic [31:0] last_out;
  int          mdl_cur_l, mdl_cur_r, mdl_tgt_l, mdl_tgt_r;
  logic        bp_done;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic int f_ramp_model(input int cur, input int eff);
    int d;
    d = eff - cur;
    if (d <= 64 && d >= -64) return eff;
    else if (d > 0)          return cur + 64;
    else                     return cur - 64;
  endfunction

  function automatic logic [15:0] f_expect(input int s, input int g);
    longint p;
    longint r;
    logic [63:0] rv;
    p = longint'(s) * longint'(g);
    r = (p + 64'sd16384) >>> 15;
    if (r > 64'sd32767)       r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    rv = r;
    return rv[15:0];
  endfunction

  // Model runs at the falling edge, seeing exactly what the next rising edge will capture.
  task automatic monitor_loop();
    logic [32:0] exp_w;
    int eff_l, eff_r;
    forever begin
      @(negedge aclk);
      if (areset) begin
        sb_q.delete();
        mdl_cur_l = 32768; mdl_cur_r = 32768;
        mdl_tgt_l = 32768; mdl_tgt_r = 32768;
      end else begin
        if (m_axis_tvalid && m_axis_tready) begin
          n_out++;
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got data=%h with nothing expected", m_axis_tdata);
          end else begin
            exp_w = sb_q.pop_front();
            if ({m_axis_tlast, m_axis_tdata} !== exp_w)
              begin
                n_fail++;
                $display("FAIL sb_data: got tlast=%0b data=%h, expected tlast=%0b data=%h",
                         m_axis_tlast, m_axis_tdata, exp_w[32], exp_w[31:0]);
              end
          end
          last_out = m_axis_tdata;
        end
        if (s_axis_tvalid && s_axis_tready) begin
          eff_l = mute ? 0 : mdl_tgt_l;
          eff_r = mute ? 0 : mdl_tgt_r;
          sb_q.push_back({s_axis_tlast,
                          f_expect($signed(s_axis_tdata[31:16]), mdl_cur_l),
                          f_expect($signed(s_axis_tdata[15:0]), mdl_cur_r)});
          mdl_cur_l = f_ramp_model(mdl_cur_l, eff_l);
          mdl_cur_r = f_ramp_model(mdl_cur_r, eff_r);
        end
        if (gain_update) begin
          mdl_tgt_l = int'(gain_l_target);
          mdl_tgt_r = int'(gain_r_target);
        end
      end
    end
  endtask

  // Present one sample and return at #1 after the edge that accepted it; valid stays high.
  task automatic send(input int l, input int r, input logic last);
    int waits;
    waits = 0;
    s_axis_tdata  = {16'(l), 16'(r)};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(negedge aclk);
    while (!s_axis_tready && waits < 1000) begin
      waits++;
      @(negedge aclk);
    end
    if (!s_axis_tready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", waits);
    end
    @(posedge aclk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    s_axis_tvalid = 1'b0;
    while (sb_q.size() != 0 && w < 200) begin
      @(posedge aclk); #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d samples still pending, required 0", sb_q.size());
    end
  endtask

  task automatic set_gain(input int gl, input int gr);
    gain_l_target = 16'(gl);
    gain_r_target = 16'(gr);
    gain_update   = 1'b1;
    @(posedge aclk); #1;
    gain_update   = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, ramp_active, sat_sticky, s_axis_tready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/last/ramp/sat/ready=%b, required 00001",
               {m_axis_tvalid, m_axis_tlast, ramp_active, sat_sticky, s_axis_tready});
    end
    n_checks++;
    if (m_axis_tdata !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 00000000", m_axis_tdata);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_unity_latency();
    send(10000, -10000, 1'b0);
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: m_axis_tvalid=%b one cycle after accept, required 0", m_axis_tvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h2710_D8F0) begin
      n_fail++;
      $display("FAIL latency_data: got valid=%b data=%h two cycles after accept, required 1 2710d8f0",
               m_axis_tvalid, m_axis_tdata);
    end
    n_checks++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_ramp: ramp_active=%b, required 0", ramp_active);
    end
    drain();
  endtask

  task automatic test_ramp_down();
    set_gain(16384, 16384);
    @(posedge aclk); #1;
    n_checks++;
    if (ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_start: ramp_active=%b after retarget, required 1", ramp_active);
    end
    for (int k = 1; k <= 300; k++) begin
      send(10000, 10000, 1'b0);
      if (k == 255 || k == 256) begin
        n_checks++;
        if (ramp_active !== (k == 255)) begin
          n_fail++;
          $display("FAIL ramp_end: ramp_active=%b after sample %0d, required %0b", ramp_active, k, k == 255);
        end
      end
    end
    drain();
    n_checks++;
    if (last_out !== {16'd5000, 16'd5000}) begin
      n_fail++;
      $display("FAIL ramp_final: got %h, required 13881388", last_out);
    end
  endtask

  task automatic test_saturation();
    set_gain(65535, 65535);
    for (int k = 0; k < 800; k++) send(10000, 10000, 1'b0);
    drain();
    n_checks++;
    if (ramp_active !== 1'b0 || sat_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_pre: ramp_active=%b sat_sticky=%b, required 0 0", ramp_active, sat_sticky);
    end
    send(30000, -30000, 1'b1);
    drain();
    n_checks++;
    if (last_out !== 32'h7FFF_8000 || sat_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clip: got data=%h sat=%b, required 7fff8000 1", last_out, sat_sticky);
    end
    clear_sat = 1'b1;
    @(posedge aclk); #1;
    clear_sat = 1'b0;
    n_checks++;
    if (sat_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: sat_sticky=%b, required 0", sat_sticky);
    end
    send(30000, -30000, 1'b0);
    s_axis_tvalid = 1'b0;
    clear_sat = 1'b1;
    @(posedge aclk); #1;
    clear_sat = 1'b0;
    n_checks++;
    if (sat_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_set_wins: sat_sticky=%b, required 1", sat_sticky);
    end
    drain();
  endtask

  task automatic test_mute();
    set_gain(32768, 32768);
    for (int k = 0; k < 600; k++) send(10000, 10000, 1'b0);
    drain();
    for (int phase = 0; phase < 2; phase++) begin
      mute = (phase == 0);
      for (int k = 1; k <= 520; k++) begin
        send(10000, 10000, 1'b0);
        if (k == 511 || k == 512) begin
          n_checks++;
          if (ramp_active !== (k == 511)) begin
            n_fail++;
            $display("FAIL mute_ramp: phase %0d ramp_active=%b after sample %0d, required %0b",
                     phase, ramp_active, k, k == 511);
          end
        end
      end
      drain();
      n_checks++;
      if (last_out !== ((phase == 0) ? 32'h0000_0000 : 32'h2710_2710)) begin
        n_fail++;
        $display("FAIL mute_level: phase %0d got %h", phase, last_out);
      end
    end
  endtask

  task automatic test_backpressure();
    int out0;
    out0 = n_out;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, (i % 16) == 15);
        s_axis_tvalid = 1'b0;
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge aclk); #1;
          m_axis_tready = ($urandom_range(0, 1) == 1);
        end
      end
      begin
        logic        prev_stall;
        logic [32:0] prev;
        prev_stall = 1'b0;
        prev = 33'h0;
        while (!bp_done) begin
          @(negedge aclk);
          if (prev_stall) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, prev}) begin
              n_fail++;
              $display("FAIL stall_hold: got valid=%b last=%b data=%h, required 1 %b %h",
                       m_axis_tvalid, m_axis_tlast, m_axis_tdata, prev[32], prev[31:0]);
            end
          end
          if (m_axis_tvalid && !m_axis_tready) begin
            n_checks++;
            if (s_axis_tready !== 1'b0) begin
              n_fail++;
              $display("FAIL stall_ready: s_axis_tready=%b while stalled, required 0", s_axis_tready);
            end
          end
          prev_stall = m_axis_tvalid && !m_axis_tready;
          prev = {m_axis_tlast, m_axis_tdata};
        end
      end
    join
    m_axis_tready = 1'b1;
    drain();
    n_checks++;
    if (n_out - out0 != 1000) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, required 1000", n_out - out0);
    end
  endtask

  task automatic test_reset_midramp();
    set_gain(65535, 65535);
    for (int k = 0; k < 100; k++) send(32767, 32767, 1'b0);
    n_checks++;
    if ({m_axis_tvalid, ramp_active, sat_sticky} !== 3'b111) begin
      n_fail++;
      $display("FAIL midramp_pre: valid/ramp/sat=%b, required 111", {m_axis_tvalid, ramp_active, sat_sticky});
    end
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    n_checks++;
    if ({m_axis_tvalid, ramp_active, sat_sticky} !== 3'b000) begin
      n_fail++;
      $display("FAIL midramp_reset: valid/ramp/sat=%b, required 000", {m_axis_tvalid, ramp_active, sat_sticky});
    end
    send(10000, -10000, 1'b1);
    drain();
    n_checks++;
    if (last_out !== 32'h2710_D8F0 || ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_unity: got data=%h ramp=%b, required 2710d8f0 0", last_out, ramp_active);
    end
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    gain_l_target = 16'h8000;
    gain_r_target = 16'h8000;
    gain_update   = 1'b0;
    mute          = 1'b0;
    clear_sat     = 1'b0;
    bp_done       = 1'b0;
    last_out      = 32'h0;
    mdl_cur_l = 32768; mdl_cur_r = 32768;
    mdl_tgt_l = 32768; mdl_tgt_r = 32768;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_unity_latency();
    test_ramp_down();
    test_saturation();
    test_mute();
    test_backpressure();
    test_reset_midramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
